// File: rtl/inst_mem_pipe_if.sv
// Load/fetch bundle for the IF-stage instruction memory.
// master drives loads and fetches; slave is the memory.
interface inst_mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 6
);
    logic              ld_we;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_done;
    logic              ready;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] inst;
    logic              inst_valid;
    logic [31:0]       fetch_pc;
    logic              align_err;

    modport master (
        output ld_we, ld_addr, ld_data, ld_done,
        output fetch_req, fetch_addr, stall, flush,
        input  ready, inst, inst_valid, fetch_pc, align_err
    );

    modport slave (
        input  ld_we, ld_addr, ld_data, ld_done,
        input  fetch_req, fetch_addr, stall, flush,
        output ready, inst, inst_valid, fetch_pc, align_err
    );
endinterface

// File: rtl/inst_mem_pipe.sv
// Loadable, registered instruction memory feeding the IF/ID register.
// Optional misaligned-fetch flagging: define IMEM_ALIGN_CHECK_EN.
module inst_mem_pipe #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    inst_mem_pipe_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic              aerr_q, aerr_d;

    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              misal;
    logic              unused_addr;

    assign rd_idx  = bus.fetch_addr[AW+1:2];
    assign rd_data = mem_q[rd_idx];

    // upper bits wrap; low bits only matter with alignment checking
    assign unused_addr = ^{bus.fetch_addr[31:AW+2], bus.fetch_addr[1:0]};

`ifdef IMEM_ALIGN_CHECK_EN
    assign misal = |bus.fetch_addr[1:0];
`else
    assign misal = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (state_q == LOAD && bus.ld_done) begin
            state_d = RUN;
        end
    end

    always_comb begin
        inst_d  = inst_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        aerr_d  = aerr_q;
        if (state_q == LOAD) begin
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
            pc_d    = '0;
            aerr_d  = 1'b0;
        end else if (bus.flush) begin
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
            aerr_d  = 1'b0;
        end else if (bus.stall) begin
            inst_d  = inst_q;
            valid_d = valid_q;
        end else if (bus.fetch_req) begin
            inst_d  = misal ? NOP_WORD : rd_data;
            valid_d = 1'b1;
            pc_d    = bus.fetch_addr;
            aerr_d  = misal;
        end else begin
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
            aerr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            inst_q  <= NOP_WORD;
            valid_q <= 1'b0;
            pc_q    <= '0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            aerr_q  <= aerr_d;
        end
    end

    // no reset on the array: the program survives rst
    always_ff @(posedge clk) begin
        if (!rst && state_q == LOAD && bus.ld_we) begin
            mem_q[bus.ld_addr] <= bus.ld_data;
        end
    end

    assign bus.ready      = (state_q == RUN);
    assign bus.inst       = inst_q;
    assign bus.inst_valid = valid_q;
    assign bus.fetch_pc   = pc_q;
    assign bus.align_err  = aerr_q;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Scoreboard bench for inst_mem_pipe: directed cycles push expected
// outputs, a monitor pops and compares after each rising edge.
module tb_inst_mem_pipe;
    logic clk;
    logic rst;

    inst_mem_pipe_if #(.DATA_W(32), .AW(6)) bus ();

    inst_mem_pipe #(
        .DATA_W  (32),
        .DEPTH   (64),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        vld;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        aerr;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk;
    int   n_fail;
    int   cyc_no;

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", nm, c, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        cyc_no = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc_no++;
                chk("ready", cyc_no, {31'b0, bus.ready}, {31'b0, e.rdy});
                chk("inst_valid", cyc_no, {31'b0, bus.inst_valid}, {31'b0, e.vld});
                chk("inst", cyc_no, bus.inst, e.inst);
                chk("fetch_pc", cyc_no, bus.fetch_pc, e.pc);
                chk("align_err", cyc_no, {31'b0, bus.align_err}, {31'b0, e.aerr});
            end
        end
    end

    task automatic cyc(
        input logic r, input logic we, input logic [5:0] la,
        input logic [31:0] ld, input logic done,
        input logic req, input logic [31:0] fa,
        input logic st, input logic fl,
        input logic x_rdy, input logic x_vld, input logic [31:0] x_inst,
        input logic [31:0] x_pc, input logic x_aerr
    );
        exp_t e;
        @(negedge clk);
        rst            = r;
        bus.ld_we      = we;
        bus.ld_addr    = la;
        bus.ld_data    = ld;
        bus.ld_done    = done;
        bus.fetch_req  = req;
        bus.fetch_addr = fa;
        bus.stall      = st;
        bus.flush      = fl;
        e.rdy  = x_rdy;
        e.vld  = x_vld;
        e.inst = x_inst;
        e.pc   = x_pc;
        e.aerr = x_aerr;
        exp_q.push_back(e);
    endtask

    task automatic run(input logic req, input logic [31:0] fa,
                       input logic st, input logic fl,
                       input logic x_vld, input logic [31:0] x_inst,
                       input logic [31:0] x_pc, input logic x_aerr);
        cyc(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, req, fa, st, fl,
            1'b1, x_vld, x_inst, x_pc, x_aerr);
    endtask

    localparam logic [31:0] W0  = 32'h4400_0001;
    localparam logic [31:0] W1  = 32'h2801_4024;
    localparam logic [31:0] W2  = 32'hDEAD_BEEF;
    localparam logic [31:0] W63 = 32'h0BAD_F00D;

    initial begin
        logic [31:0] mis_inst;
        logic        mis_aerr;
        int          wait_cnt;
`ifdef IMEM_ALIGN_CHECK_EN
        mis_inst = 32'h0;
        mis_aerr = 1'b1;
`else
        mis_inst = W1;
        mis_aerr = 1'b0;
`endif
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.ld_we = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        bus.ld_done = 1'b0;
        bus.fetch_req = 1'b0;
        bus.fetch_addr = '0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load; fetch/stall/flush ignored while loading
        cyc(0, 1, 6'd0, W0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 6'd1, W1, 0, 1, 32'h4, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 6'd2, W2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // write in the ld_done cycle still lands
        cyc(0, 1, 6'd63, W63, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // 1: basic fetch
        run(1, 32'h0, 0, 0, 1, W0, 32'h0, 0);
        // 2: fetch then 3-cycle stall
        run(1, 32'h4, 0, 0, 1, W1, 32'h4, 0);
        run(1, 32'h8, 1, 0, 1, W1, 32'h4, 0);
        run(1, 32'h8, 1, 0, 1, W1, 32'h4, 0);
        run(1, 32'h8, 1, 0, 1, W1, 32'h4, 0);
        run(1, 32'h8, 0, 0, 1, W2, 32'h8, 0);
        // 3: flush beats stall and fetch
        run(1, 32'h4, 1, 1, 0, 32'h0, 32'h8, 0);
        run(0, 32'h0, 0, 0, 0, 32'h0, 32'h8, 0);
        // 4: wrap and last word
        run(1, 32'h104, 0, 0, 1, W1, 32'h104, 0);
        run(1, 32'hFC, 0, 0, 1, W63, 32'hFC, 0);
        // 5: write ignored in RUN
        cyc(0, 1, 6'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0, 0, 32'hFC, 0);
        run(1, 32'h0, 0, 0, 1, W0, 32'h0, 0);
        // 6: misaligned fetch, hold under stall, clear on flush
        run(1, 32'h6, 0, 0, 1, mis_inst, 32'h6, mis_aerr);
        run(0, 32'h0, 1, 0, 1, mis_inst, 32'h6, mis_aerr);
        run(1, 32'h0, 0, 1, 0, 32'h0, 32'h6, 0);
        // rst mid-RUN keeps the program
        cyc(1, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
        run(1, 32'h0, 0, 0, 1, W0, 32'h0, 0);
        run(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
